threshold_estimator: RTL
========================

# threshold_estimator

Computes the wavelet-shrinkage threshold base value for the ECG denoising path. Each frame of detail-coefficient pairs (IEEE-754 single precision) is reduced to its maximum absolute value. The result drives `thresh` of the downstream thresholding unit, which applies its own scale factor. Magnitude ordering uses unsigned integer comparison of bits [30:0], which is exact for non-NaN floats, so the block needs no floating-point unit.

## Interface
- `FRAME_LEN`, default 256: number of coefficient pairs per frame; legal range 2..65536.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- `in_valid`  input  1  `a`/`b` hold a valid coefficient pair this cycle; honoured only in ACCUM.
- `a`  input  32  IEEE-754 coefficient, first of pair.
- `b`  input  32  IEEE-754 coefficient, second of pair.
- `thresh`  output  32  max |coefficient| of the last completed frame; bit 31 always 0.
- `thresh_valid`  output  1  one-cycle pulse when `thresh` has just been updated.
- `busy`  output  1  high while in ACCUM.
- `nan_seen`  output  1  sticky; at least one NaN was dropped in the current or last frame.

## Operation
- Two states, IDLE and ACCUM. Reset enters IDLE.
- IDLE:
  - `start`=1 clears the running max to 0, the pair counter to 0, and `nan_seen` to 0, then moves to ACCUM.
  - `in_valid` is ignored in IDLE, including a pair that arrives in the same cycle as `start`.
- ACCUM: on each `in_valid`=1 cycle:
  - Form `ma`={1'b0,a[30:0]} and `mb`={1'b0,b[30:0]}.
  - A value is NaN when exponent = 8'hFF and mantissa ≠ 0. A NaN value is excluded from the max and sets `nan_seen`.
  - Infinity (exponent 8'hFF, mantissa 0) and denormals participate normally.
  - New running max = unsigned max of (running max, `ma` if not NaN, `mb` if not NaN).
  - The pair counter increments.
- `start` is ignored in ACCUM; a frame cannot be restarted early.
- Frame end: the cycle that accepts pair number FRAME_LEN loads `thresh` with the new running max, which includes that final pair. At the same edge the block returns to IDLE and pulses `thresh_valid`.
- `thresh` holds its value between frames. It changes only at frame end or on reset.
- A frame made entirely of NaNs gives `thresh` = 32'h0000_0000 with `nan_seen`=1.
- Pair counter width: $clog2(FRAME_LEN+1). The counter never wraps inside a frame.
- Negative zero gives magnitude 0.

## Timing
- Reset values: `thresh`=0, `thresh_valid`=0, `busy`=0, `nan_seen`=0. State is IDLE, and the running max and counter are 0.
- Reset asserted mid-frame aborts the frame immediately; the partial max is discarded and no `thresh_valid` is produced.
- `start` sampled at edge k: `busy`=1 from k+1, and the first pair is accepted at edge k+1 at the earliest.
- Last pair accepted at edge n:
  - `thresh` shows the new value after n.
  - `thresh_valid`=1 for the cycle between edges n and n+1 only.
  - `busy`=0 after n.
- A `start` in that `thresh_valid` cycle is honoured, giving back-to-back frames with one idle cycle.
- Gaps in `in_valid` stall accumulation with no timeout.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `nan_seen` updates at the edge that accepts the NaN pair.

## Test plan
- Reset, then FRAME_LEN=4 with pairs (3F800000, C0200000), (3F000000, 0), (0, 0), (BF000000, 3F800000) -> `thresh`=40200000 (2.5) and `thresh_valid` pulses exactly one cycle after the 4th pair. `nan_seen`=0.
- NaN handling: a frame containing 7FC00000 and FFC00000 with otherwise max 40400000 -> `thresh`=40400000, `nan_seen`=1. An all-NaN frame -> `thresh`=0, `nan_seen`=1.
- Infinity: the frame includes FF800000 -> `thresh`=7F800000.
- Protocol edges:
  - `in_valid` with `start` in IDLE is dropped, so the frame still needs 4 more pairs.
  - `start` during ACCUM is ignored.
  - `in_valid` gaps do not change the result.
  - `start` during the `thresh_valid` cycle begins the next frame and `thresh` holds the old value until that frame ends.
- Reset mid-frame after 2 pairs: all outputs return to 0 asynchronously. A new full frame then produces the correct max, unaffected by the aborted pairs.
- Random regression: 1000 frames of random floats at FRAME_LEN=256 with random `in_valid` gaps, compared against a reference model of max over non-NaN |x|.

Source files
------------

// File: rtl/threshold_estimator_if.sv
// threshold_estimator_if
//   Handshake and data bundle between a coefficient source and
//   threshold_estimator.
//   master : drives start/in_valid/a/b and receives the threshold outputs
//   slave  : the estimator side
//   start        - one-cycle frame start pulse
//   in_valid     - a/b carry a valid coefficient pair
//   a, b         - IEEE-754 single-precision coefficients
//   thresh       - max |coefficient| of the last completed frame
//   thresh_valid - one-cycle pulse when thresh has just been updated
//   busy         - frame accumulation in progress
//   nan_seen     - sticky NaN-dropped flag for the current/last frame
interface threshold_estimator_if;
    logic        start;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] thresh;
    logic        thresh_valid;
    logic        busy;
    logic        nan_seen;

    modport master (
        output start, in_valid, a, b,
        input  thresh, thresh_valid, busy, nan_seen
    );

    modport slave (
        input  start, in_valid, a, b,
        output thresh, thresh_valid, busy, nan_seen
    );
endinterface

// File: rtl/threshold_estimator.sv
// threshold_estimator
//   Reduces each frame of FRAME_LEN IEEE-754 coefficient pairs to the
//   maximum absolute value, used as the wavelet-shrinkage threshold base.
//   Magnitudes are ordered by unsigned compare of bits [30:0], which is
//   exact for non-NaN floats. NaNs are dropped and flagged.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - threshold_estimator_if.slave (start/in_valid/a/b in,
//           thresh/thresh_valid/busy/nan_seen out, all registered)
module threshold_estimator #(
    parameter int FRAME_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    threshold_estimator_if.slave  bus
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t          state;
    logic [CW-1:0]   pair_cnt;
    logic [31:0]     run_max;
    logic [31:0]     thresh_q;
    logic            thresh_valid_q;
    logic            busy_q;
    logic            nan_seen_q;

    logic [31:0]     ma;
    logic [31:0]     mb;
    logic            na;
    logic            nb;
    logic [31:0]     max_next;
    logic            last_pair;

    always_comb begin
        // Masking the sign bit keeps the full input word in use and
        // maps -0 to magnitude 0.
        ma = bus.a & 32'h7FFF_FFFF;
        mb = bus.b & 32'h7FFF_FFFF;
        na = (ma[30:23] == 8'hFF) && (ma[22:0] != '0);
        nb = (mb[30:23] == 8'hFF) && (mb[22:0] != '0);
        max_next = run_max;
        if (!na && (ma > max_next)) max_next = ma;
        if (!nb && (mb > max_next)) max_next = mb;
        last_pair = (pair_cnt == CW'(FRAME_LEN - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pair_cnt       <= '0;
            run_max        <= '0;
            thresh_q       <= '0;
            thresh_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            nan_seen_q     <= 1'b0;
        end else begin
            thresh_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    // in_valid is deliberately not looked at here.
                    if (bus.start) begin
                        run_max    <= '0;
                        pair_cnt   <= '0;
                        nan_seen_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        run_max  <= max_next;
                        pair_cnt <= pair_cnt + CW'(1);
                        if (na || nb) nan_seen_q <= 1'b1;
                        if (last_pair) begin
                            thresh_q       <= max_next;
                            thresh_valid_q <= 1'b1;
                            busy_q         <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.thresh       = thresh_q;
    assign bus.thresh_valid = thresh_valid_q;
    assign bus.busy         = busy_q;
    assign bus.nan_seen     = nan_seen_q;
endmodule
